axis_bram_writer_mc: RTL and testbench
======================================

Name: axis_bram_writer_mc

Overview:
- Parametrised successor to the DSKW stream-input path: an AXI-Stream slave that unpacks each TDATA beat into WIDTH-bit samples.
- Samples are written round-robin into NUM_BANKS BRAM banks over the bram-style port.
- Block enforces a programmed sample count, drains over-long frames, flags short/long frames and pulses done_interrupt on completion.
- Sits between the DMA stream and the SVM core's sample/support-vector memories.

Parameters:
- WIDTH, 16, sample width and BRAM data width.
- C_S_AXIS_TDATA_WIDTH, 32, stream data width; must be an integer multiple of WIDTH. LANES = C_S_AXIS_TDATA_WIDTH/WIDTH.
- NUM_BANKS, 2, number of BRAM banks, >=1; samples interleaved across banks.
- DEPTH, 1024, words per bank; the address counter wraps modulo DEPTH.
- CNT_WIDTH, 16, width of the sample-count registers.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle start pulse; honoured only in IDLE.
- num_samples  in  CNT_WIDTH  expected sample count; latched on start.
- s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  stream data; lane0 = bits [WIDTH-1:0].
- s_axis_tvalid  in  1  stream valid.
- s_axis_tlast  in  1  end of frame.
- s_axis_tready  out  1  stream ready.
- axi_address  out  32  word address within the selected bank.
- axi_in_data  out  WIDTH  write data.
- axi_en  out  1  BRAM enable.
- axi_we  out  1  BRAM write enable.
- bank_sel  out  NUM_BANKS  one-hot bank select, valid while axi_en=1.
- busy  out  1  high in any state other than IDLE.
- samples_written  out  CNT_WIDTH  samples written this frame.
- err_short  out  1  tlast arrived before num_samples were written; sticky until the next start.
- err_long  out  1  num_samples reached before tlast; sticky until the next start.
- done_interrupt  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0, all counters 0, bank pointer 0, address 0.
- States: IDLE, ACCEPT, WRITE, DRAIN, DONE.
- IDLE:
  - On start=1: latch num_samples; clear samples_written, err flags, bank pointer and address.
  - If num_samples=0, go to DONE; otherwise go to ACCEPT.
- ACCEPT:
  - s_axis_tready=1.
  - On tvalid&tready: capture tdata and tlast, set the lane index to 0, go to WRITE.
  - tvalid low stalls here indefinitely.
- WRITE (s_axis_tready=0): write one sample per cycle.
  - Drive axi_en=1, axi_we=1, bank_sel=onehot(bank_ptr), axi_address=addr, axi_in_data=lane[lane_idx].
  - Then increment samples_written and lane_idx.
  - Increment bank_ptr; when bank_ptr wraps from NUM_BANKS-1 to 0, increment addr (modulo DEPTH).
- Priority after each write:
  1. samples_written+1 == num_samples: remaining lanes are discarded. If the captured tlast=1, go to DONE. Otherwise set err_long and go to DRAIN.
  2. Last lane written and captured tlast=1: set err_short, go to DONE.
  3. Last lane written: go to ACCEPT.
  4. Otherwise: stay in WRITE.
- If num_samples coincides with the tlast beat, that is not an error.
- DRAIN:
  - s_axis_tready=1; beats are accepted and discarded.
  - On an accepted beat with tlast=1, go to DONE. No BRAM writes occur.
- DONE: done_interrupt=1 for exactly one cycle, then go to IDLE. Flags and samples_written hold until the next start.
- Throughput and latency:
  - Throughput is LANES+1 cycles per beat.
  - The first BRAM write occurs the cycle after the beat is accepted.
- Boundary cases:
  - start outside IDLE is ignored.
  - Address wrap past DEPTH-1 silently overwrites from 0.
  - Reset mid-frame aborts immediately, with no further writes and no done pulse.
  - axi_en/axi_we are never asserted outside WRITE.

Test Plan (WIDTH=16, TDATA=32, NUM_BANKS=2, DEPTH=4):
- Exact frame: num_samples=4; beats 0x0002_0001, then 0x0004_0003 with tlast.
  - Writes: b0@0=0x0001, b1@0=0x0002, b0@1=0x0003, b1@1=0x0004.
  - done_interrupt pulses once; samples_written=4; both err flags 0.
- Truncate on last beat: num_samples=3, same beats.
  - Three writes; 0x0004 is not written; done pulses; err flags 0.
- Short frame: num_samples=6, same two beats.
  - Four writes; err_short=1, err_long=0; samples_written=4; done pulses.
- Long frame: num_samples=2; three beats, tlast on the 3rd.
  - Two writes, then 2 beats drained with tready=1; err_long=1.
  - done pulses only after the 3rd beat is accepted.
- Stall and wrap: num_samples=10 with random tvalid gaps and tlast on the 5th beat.
  - Addresses 0,0,1,1,2,2,3,3,0,0 per bank pair.
  - No writes occur during gaps; done pulses once.
- Zero length, ignored start and reset mid-frame:
  - num_samples=0: done pulses 2 cycles after start, with no tready and no writes.
  - A second start while busy has no effect.
  - rst asserted during WRITE: all outputs are 0 in the same cycle; after release the block is in IDLE and no writes occur.

Source files
------------

// File: rtl/axis_bram_writer_mc_if.sv
// Stream input plus banked BRAM write port seen by axis_bram_writer_mc.
// slave is the writer's view; master is the view of the stream source and BRAM side.
interface axis_bram_writer_mc_if #(
  parameter int unsigned WIDTH                = 16,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned NUM_BANKS            = 2
) ();
  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
  logic                            s_axis_tvalid;
  logic                            s_axis_tlast;
  logic                            s_axis_tready;
  logic [31:0]                     axi_address;
  logic [WIDTH-1:0]                axi_in_data;
  logic                            axi_en;
  logic                            axi_we;
  logic [NUM_BANKS-1:0]            bank_sel;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready, axi_address, axi_in_data, axi_en, axi_we, bank_sel
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready, axi_address, axi_in_data, axi_en, axi_we, bank_sel
  );
endinterface

// File: rtl/axis_bram_writer_mc.sv
// AXI-Stream to multi-bank BRAM writer: unpacks beats into WIDTH-bit samples, writes them
// round-robin across banks, enforces a sample count and flags short/long frames.
module axis_bram_writer_mc #(
  parameter int unsigned WIDTH                = 16,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned NUM_BANKS            = 2,
  parameter int unsigned DEPTH                = 1024,
  parameter int unsigned CNT_WIDTH            = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_samples,
  axis_bram_writer_mc_if.slave  bus,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  samples_written,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  done_interrupt
);
  localparam int unsigned LANES = C_S_AXIS_TDATA_WIDTH / WIDTH;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {StIdle, StAccept, StWrite, StDrain, StDone} state_e;

  state_e                          state;
  logic [CNT_WIDTH-1:0]            num_lat;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] beat_data;
  logic                            beat_last;
  logic [LW-1:0]                   lane_idx;
  logic [BW-1:0]                   bank_ptr;
  logic [AW-1:0]                   addr;
  logic                            tready;
  logic                            wr_en;
  logic [NUM_BANKS-1:0]            wr_bank;
  logic [31:0]                     wr_addr;
  logic [WIDTH-1:0]                wr_data;

  logic [CNT_WIDTH-1:0]            sw_inc;
  logic                            count_hit;
  logic                            lane_last;
  logic [LW-1:0]                   lane_nxt;
  logic [BW-1:0]                   bank_nxt;
  logic [AW-1:0]                   addr_nxt;
  logic [WIDTH-1:0]                lane_nxt_data;

  // Pointers for the write following the one on the port this cycle.
  always_comb begin
    sw_inc        = samples_written + CNT_WIDTH'(1);
    count_hit     = (sw_inc == num_lat);
    lane_last     = (lane_idx == LW'(LANES - 1));
    lane_nxt      = lane_last ? '0 : lane_idx + LW'(1);
    lane_nxt_data = beat_data[lane_nxt * WIDTH +: WIDTH];
    if (bank_ptr == BW'(NUM_BANKS - 1)) begin
      bank_nxt = '0;
      addr_nxt = (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
    end else begin
      bank_nxt = bank_ptr + BW'(1);
      addr_nxt = addr;
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.axi_en        = wr_en;
  assign bus.axi_we        = wr_en;
  assign bus.bank_sel      = wr_bank;
  assign bus.axi_address   = wr_addr;
  assign bus.axi_in_data   = wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= StIdle;
      num_lat         <= '0;
      beat_data       <= '0;
      beat_last       <= 1'b0;
      lane_idx        <= '0;
      bank_ptr        <= '0;
      addr            <= '0;
      tready          <= 1'b0;
      wr_en           <= 1'b0;
      wr_bank         <= '0;
      wr_addr         <= '0;
      wr_data         <= '0;
      busy            <= 1'b0;
      samples_written <= '0;
      err_short       <= 1'b0;
      err_long        <= 1'b0;
      done_interrupt  <= 1'b0;
    end else begin
      done_interrupt <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            num_lat         <= num_samples;
            samples_written <= '0;
            err_short       <= 1'b0;
            err_long        <= 1'b0;
            bank_ptr        <= '0;
            addr            <= '0;
            lane_idx        <= '0;
            busy            <= 1'b1;
            if (num_samples == '0) begin
              state <= StDone;
            end else begin
              state  <= StAccept;
              tready <= 1'b1;
            end
          end
        end
        StAccept: begin
          if (bus.s_axis_tvalid) begin
            beat_data <= bus.s_axis_tdata;
            beat_last <= bus.s_axis_tlast;
            lane_idx  <= '0;
            tready    <= 1'b0;
            wr_en     <= 1'b1;
            wr_bank   <= NUM_BANKS'(1) << bank_ptr;
            wr_addr   <= 32'(addr);
            wr_data   <= bus.s_axis_tdata[WIDTH-1:0];
            state     <= StWrite;
          end
        end
        StWrite: begin
          samples_written <= sw_inc;
          lane_idx        <= lane_nxt;
          bank_ptr        <= bank_nxt;
          addr            <= addr_nxt;
          if (count_hit || lane_last) begin
            wr_en   <= 1'b0;
            wr_bank <= '0;
            // Count reached wins over end-of-beat; leftover lanes are dropped.
            if (count_hit && beat_last) begin
              state <= StDone;
            end else if (count_hit) begin
              err_long <= 1'b1;
              tready   <= 1'b1;
              state    <= StDrain;
            end else if (beat_last) begin
              err_short <= 1'b1;
              state     <= StDone;
            end else begin
              tready <= 1'b1;
              state  <= StAccept;
            end
          end else begin
            wr_bank <= NUM_BANKS'(1) << bank_nxt;
            wr_addr <= 32'(addr_nxt);
            wr_data <= lane_nxt_data;
          end
        end
        StDrain: begin
          if (bus.s_axis_tvalid && bus.s_axis_tlast) begin
            tready <= 1'b0;
            state  <= StDone;
          end
        end
        StDone: begin
          done_interrupt <= 1'b1;
          busy           <= 1'b0;
          state          <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_bram_writer_mc.sv
// Randomised bench for axis_bram_writer_mc: frames are driven beat by beat and the BRAM
// write log, flags and done pulse are compared against a flat sample-index model.
module tb_axis_bram_writer_mc;
  localparam int unsigned W     = 16;
  localparam int unsigned TW    = 32;
  localparam int unsigned NB    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned LANES = TW / W;
  localparam int unsigned REC   = NB + 32 + W;
  localparam int unsigned OFW   = NB + CW + 7 + 32 + W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic          busy, err_short, err_long, done_interrupt;
  logic [CW-1:0] samples_written;

  axis_bram_writer_mc_if #(.WIDTH(W), .C_S_AXIS_TDATA_WIDTH(TW), .NUM_BANKS(NB)) bus ();

  axis_bram_writer_mc #(
    .WIDTH(W), .C_S_AXIS_TDATA_WIDTH(TW), .NUM_BANKS(NB), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .bus(bus),
    .busy(busy), .samples_written(samples_written), .err_short(err_short),
    .err_long(err_long), .done_interrupt(done_interrupt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int failed = 0;
  int cyc = 0;
  int done_total = 0;
  int done_cyc = 0;
  int proto_err = 0;
  logic [REC-1:0] wr_q[$];
  logic [REC-1:0] exp_q[$];
  logic [TW-1:0]  beat_data[$];
  bit             beat_last[$];
  int  exp_sw, acc_cyc, wr_base, done_base;
  bit  exp_short, exp_long, timed_out;

  logic [OFW-1:0] out_flat;
  assign out_flat = {bus.s_axis_tready, bus.axi_en, bus.axi_we, bus.bank_sel, busy,
                     samples_written, err_short, err_long, done_interrupt, bus.axi_address,
                     bus.axi_in_data};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.axi_en === 1'b1) wr_q.push_back({bus.bank_sel, bus.axi_address, bus.axi_in_data});
    if (done_interrupt === 1'b1) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
    if ((bus.axi_en && bus.s_axis_tready) || (bus.axi_we !== bus.axi_en)) proto_err <= proto_err + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Sample k goes to bank k%NB at word (k/NB)%DEPTH; stops at the count or at tlast.
  task automatic model(input int num);
    int k;
    logic [TW-1:0] d;
    k = 0;
    exp_q.delete();
    exp_short = 0;
    exp_long = 0;
    if (num != 0) begin
      foreach (beat_data[b]) begin
        d = beat_data[b];
        for (int l = 0; l < int'(LANES) && k < num; l++) begin
          exp_q.push_back({NB'(1) << (k % NB), 32'((k / NB) % DEPTH), d[l*W +: W]});
          k++;
        end
        if (k == num) begin
          exp_long = !beat_last[b];
          break;
        end
        if (beat_last[b]) begin
          exp_short = 1;
          break;
        end
      end
    end
    exp_sw = k;
  endtask

  // Called at a negedge; drives start, all queued beats with random gaps, waits for done.
  task automatic run_frame(input int num, input int gap_max, input bit poke);
    int t;
    bit hs;
    timed_out = 0;
    wr_base = wr_q.size();
    done_base = done_total;
    start = 1'b1;
    num_samples = CW'(num);
    @(negedge clk);
    start = 1'b0;
    foreach (beat_data[b]) begin
      if (poke && b == 1) begin
        start = 1'b1;
        num_samples = CW'(1);
        @(negedge clk);
        start = 1'b0;
        num_samples = CW'(num);
      end
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      bus.s_axis_tdata  = beat_data[b];
      bus.s_axis_tlast  = beat_last[b];
      bus.s_axis_tvalid = 1'b1;
      t = 0;
      do begin
        hs = bus.s_axis_tready;
        @(negedge clk);
        t++;
      end while (!hs && t < 300);
      if (!hs) timed_out = 1;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      acc_cyc = cyc;
    end
    t = 0;
    while (done_total == done_base && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (done_total == done_base) timed_out = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (out_flat !== '0) begin
      failed++;
      $display("FAIL reset outputs: got %h want 0", out_flat);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || bus.s_axis_tready !== 1'b0) begin
      failed++;
      $display("FAIL post-reset idle: busy=%b tready=%b want 0/0", busy, bus.s_axis_tready);
    end
  endtask

  task automatic test_directed_frames();
    string nm [6] = '{"exact", "truncate", "short", "long", "stall_wrap", "ignored_start"};
    int    num[6] = '{4, 3, 6, 2, 10, 4};
    int    nbeats;
    for (int s = 0; s < 6; s++) begin
      beat_data.delete();
      beat_last.delete();
      nbeats = (s == 3) ? 3 : (s == 4) ? 5 : 2;
      for (int b = 0; b < nbeats; b++) begin
        beat_data.push_back((s == 4) ? TW'($urandom) : {16'(2 * b + 2), 16'(2 * b + 1)});
        beat_last.push_back(b == nbeats - 1);
      end
      model(num[s]);
      run_frame(num[s], (s == 4) ? 3 : 0, s == 5);
      compared++;
      if (timed_out) begin
        failed++;
        $display("FAIL %s handshake: got timeout want all beats accepted and done", nm[s]);
      end
      compared++;
      if (done_total - done_base != 1) begin
        failed++;
        $display("FAIL %s done count: got %0d want 1", nm[s], done_total - done_base);
      end
      compared++;
      if (done_cyc <= acc_cyc) begin
        failed++;
        $display("FAIL %s done timing: got cycle %0d want after %0d", nm[s], done_cyc, acc_cyc);
      end
      compared++;
      if (samples_written !== CW'(exp_sw) || err_short !== exp_short || err_long !== exp_long) begin
        failed++;
        $display("FAIL %s status: got sw=%0d short=%b long=%b want sw=%0d short=%b long=%b",
                 nm[s], samples_written, err_short, err_long, exp_sw, exp_short, exp_long);
      end
      compared++;
      if (wr_q.size() - wr_base != exp_q.size()) begin
        failed++;
        $display("FAIL %s write count: got %0d want %0d", nm[s], wr_q.size() - wr_base,
                 exp_q.size());
      end
      foreach (exp_q[i]) begin
        compared++;
        if (wr_base + i >= wr_q.size() || wr_q[wr_base + i] !== exp_q[i]) begin
          failed++;
          $display("FAIL %s write[%0d]: got %h want %h", nm[s], i,
                   (wr_base + i < wr_q.size()) ? wr_q[wr_base + i] : 'x, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_zero_length();
    int  c0, wb, db;
    bit  saw_ready;
    saw_ready = 0;
    wb = wr_q.size();
    db = done_total;
    c0 = cyc;
    bus.s_axis_tdata  = 32'h1234_5678;
    bus.s_axis_tlast  = 1'b1;
    bus.s_axis_tvalid = 1'b1;
    start = 1'b1;
    num_samples = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      if (bus.s_axis_tready) saw_ready = 1;
      @(negedge clk);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    compared++;
    if (done_total - db != 1 || done_cyc - c0 != 2) begin
      failed++;
      $display("FAIL zero_len done: got count=%0d latency=%0d want 1/2", done_total - db,
               done_cyc - c0);
    end
    compared++;
    if (saw_ready || wr_q.size() != wb) begin
      failed++;
      $display("FAIL zero_len quiet: got ready=%b writes=%0d want 0/0", saw_ready,
               wr_q.size() - wb);
    end
    compared++;
    if (samples_written !== '0 || err_short !== 1'b0 || err_long !== 1'b0) begin
      failed++;
      $display("FAIL zero_len status: got sw=%0d short=%b long=%b want 0/0/0",
               samples_written, err_short, err_long);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t, wb, db;
    t = 0;
    start = 1'b1;
    num_samples = CW'(4);
    @(negedge clk);
    start = 1'b0;
    bus.s_axis_tdata  = 32'h0002_0001;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    while (bus.axi_en !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    compared++;
    if (bus.axi_en !== 1'b1) begin
      failed++;
      $display("FAIL reset_mid reach write: got en=%b want 1", bus.axi_en);
    end
    bus.s_axis_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    compared++;
    if (out_flat !== '0) begin
      failed++;
      $display("FAIL reset_mid outputs: got %h want 0", out_flat);
    end
    wb = wr_q.size();
    db = done_total;
    @(negedge clk);
    rst = 1'b0;
    bus.s_axis_tlast  = 1'b1;
    bus.s_axis_tvalid = 1'b1;
    repeat (6) @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    compared++;
    if (wr_q.size() != wb || done_total != db || busy !== 1'b0 || bus.s_axis_tready !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid aftermath: got writes=%0d done=%0d busy=%b tready=%b want 0/0/0/0",
               wr_q.size() - wb, done_total - db, busy, bus.s_axis_tready);
    end
  endtask

  task automatic test_random_frames();
    int num, nbeats;
    for (int f = 0; f < 10; f++) begin
      beat_data.delete();
      beat_last.delete();
      num = $urandom_range(12, 1);
      nbeats = $urandom_range(6, 1);
      for (int b = 0; b < nbeats; b++) begin
        beat_data.push_back(TW'($urandom));
        beat_last.push_back(b == nbeats - 1);
      end
      model(num);
      run_frame(num, 2, 0);
      compared++;
      if (timed_out || done_total - done_base != 1 || done_cyc <= acc_cyc) begin
        failed++;
        $display("FAIL rand%0d done: got timeout=%b count=%0d want 0/1 after last beat", f,
                 timed_out, done_total - done_base);
      end
      compared++;
      if (samples_written !== CW'(exp_sw) || err_short !== exp_short || err_long !== exp_long) begin
        failed++;
        $display("FAIL rand%0d status: got sw=%0d short=%b long=%b want sw=%0d short=%b long=%b",
                 f, samples_written, err_short, err_long, exp_sw, exp_short, exp_long);
      end
      compared++;
      if (wr_q.size() - wr_base != exp_q.size()) begin
        failed++;
        $display("FAIL rand%0d write count: got %0d want %0d", f, wr_q.size() - wr_base,
                 exp_q.size());
      end
      foreach (exp_q[i]) begin
        compared++;
        if (wr_base + i >= wr_q.size() || wr_q[wr_base + i] !== exp_q[i]) begin
          failed++;
          $display("FAIL rand%0d write[%0d]: got %h want %h", f, i,
                   (wr_base + i < wr_q.size()) ? wr_q[wr_base + i] : 'x, exp_q[i]);
        end
      end
    end
    compared++;
    if (proto_err != 0) begin
      failed++;
      $display("FAIL protocol: got %0d write/ready overlaps or en!=we want 0", proto_err);
    end
  endtask

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    test_reset();
    test_directed_frames();
    test_zero_length();
    test_reset_mid_frame();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
